// File: rtl/arb_mem_pkg.sv
// Shared types and constants for the two-requester memory-port arbiter.
package arb_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ACK    = 2'b10
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: forced CPU slot, then loader lock, then round robin.
module arb_pick
  import arb_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       lock_i,
  input  logic       expired_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = 1'b0;
    winner_o = REQ_CPU;
    if (expired_i && req_i[REQ_CPU]) begin
      valid_o  = 1'b1;
      winner_o = REQ_CPU;
    end else if (lock_i) begin
      valid_o  = req_i[REQ_LDR];
      winner_o = REQ_LDR;
    end else if (&req_i) begin
      valid_o  = 1'b1;
      winner_o = ~last_i;
    end else if (req_i[REQ_CPU]) begin
      valid_o  = 1'b1;
      winner_o = REQ_CPU;
    end else if (req_i[REQ_LDR]) begin
      valid_o  = 1'b1;
      winner_o = REQ_LDR;
    end
  end

endmodule

// File: rtl/arb_mem.sv
// Serialises CPU and loader accesses onto one synchronous RAM port with
// round-robin priority and a bounded loader lock.
module arb_mem
  import arb_mem_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_LIMIT = CW'(MAX_LOCK);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_q, last_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    req_m;
  logic          pend_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          expired;
  logic          pick_valid;
  logic          pick_winner;

  // Lock bookkeeping is resolved before arbitration so the cycle that acks a
  // locked loader access already arbitrates under the new lock state.
  always_comb begin
    req_m    = '0;
    pend_nxt = pend_q;
    cnt_nxt  = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        req_m = {req1, req0};
        if (!lock1) begin
          pend_nxt = 1'b0;
          cnt_nxt  = '0;
        end
      end
      ST_ACK: begin
        req_m          = {req1, req0};
        req_m[owner_q] = 1'b0;
        if (owner_q == REQ_LDR) begin
          if (lock1) begin
            pend_nxt = 1'b1;
            if (cnt_q != LOCK_LIMIT) cnt_nxt = cnt_q + CW'(1);
          end else begin
            pend_nxt = 1'b0;
            cnt_nxt  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign expired = (cnt_nxt >= LOCK_LIMIT);

  arb_pick u_pick (
    .req_i     (req_m),
    .last_i    (last_q),
    .lock_i    (pend_nxt),
    .expired_i (expired),
    .valid_o   (pick_valid),
    .winner_o  (pick_winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    pend_d  = pend_nxt;
    cnt_d   = cnt_nxt;
    unique case (state_q)
      ST_IDLE, ST_ACK: begin
        if (pick_valid) begin
          state_d = ST_ACCESS;
          owner_d = pick_winner;
          last_d  = pick_winner;
          we_d    = (pick_winner == REQ_LDR) ? we1    : we0;
          addr_d  = (pick_winner == REQ_LDR) ? addr1  : addr0;
          wdata_d = (pick_winner == REQ_LDR) ? wdata1 : wdata0;
          if (pick_winner == REQ_CPU && expired) begin
            cnt_d  = '0;
            pend_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: state_d = ST_ACK;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= REQ_LDR;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign gnt       = (state_q == ST_ACCESS || state_q == ST_ACK) ? owner_onehot(owner_q) : '0;
  assign ack0      = (state_q == ST_ACK) && (owner_q == REQ_CPU);
  assign ack1      = (state_q == ST_ACK) && (owner_q == REQ_LDR);
  assign rdata     = (state_q == ST_ACK) ? mem_rdata : '0;
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = (state_q == ST_ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: doc/arb_mem.md
# arb_mem

Two-requester arbiter for the single shared memory port of the multicycle CPU. Requester 0 is the CPU control unit (fetch, operand and write-back accesses); requester 1 is the program loader / I/O side. The block serialises accesses, applies round-robin priority and supports a bounded loader lock for burst program loads. It sits between both requesters and the synchronous RAM.

## Interface
Parameters:
- AW, 8, address width
- DW, 8, data width
- MAX_LOCK, 16, max consecutive locked loader accesses before a forced CPU slot (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- req0, req1  in  1 each  access request, held until matching ack
- we0, we1  in  1 each  1 = write, 0 = read; stable while req high
- addr0, addr1  in  AW each  address; stable while req high
- wdata0, wdata1  in  DW each  write data; stable while req high
- lock1  in  1  loader asks to keep ownership after current access
- ack0, ack1  out  1 each  one-cycle completion pulse
- rdata  out  DW  read data, valid only in an ack cycle of a read
- gnt  out  2  one-hot owner during ACCESS and ACK, else 00
- busy  out  1  high when state ≠ IDLE
- mem_en  out  1  RAM enable, one cycle per access
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: if any req, pick winner, register owner/we/addr/wdata, go to ACCESS; else stay.
- ACCESS: mem_en=1, mem_we/addr/wdata from registered owner copy; go to ACK unconditionally.
- ACK: ack of owner =1, rdata = mem_rdata; arbitrate among requests excluding the owner just acked (its req is ignored this cycle) and the lock rule; winner → ACCESS, none → IDLE.
- Round robin: register `last` (0/1). Both requesting → grant the one ≠ last. Single request → grant it. `last` updates on every grant.
- Lock: a loader grant with lock1=1 sampled in ACK makes loader the only eligible requester at the next arbitration (CPU waits), even if the loader req drops (then go IDLE, lock stays pending until lock1=0 in IDLE). Lock counter counts consecutive locked loader accesses; on reaching MAX_LOCK with req0 high, the next grant goes to CPU for one access, counter clears. lock1=0 clears counter.
- Reset values: all outputs 0, state IDLE, last=1 (CPU wins first tie), lock counter 0.

## Timing
- Request seen in IDLE at cycle n: mem_en at n+1, ack and rdata at n+2; earliest next ACCESS n+3.
- Back-to-back from ACK: throughput one access per 2 cycles.
- Write: mem_we=1 in ACCESS cycle only; ack follows; rdata don't care.
- Requester may reassert req in the cycle after its ack; seen at next arbitration point.
- req dropped before ack: protocol violation, behaviour undefined; not checked.
- rst_n low in any state, including ACCESS/ACK: next edge → IDLE, in-flight access dropped without ack, mem_en 0.
- mem outputs are registered; gnt/ack/busy decoded from registered state only.

## Structure
- Shared package: state encoding (IDLE=2'b00, ACCESS=2'b01, ACK=2'b10), requester index constants REQ_CPU=0, REQ_LDR=1.
- One natural sub-module: arb_pick, combinational winner select from req vector, last, lock flag and lock-count-expired flag.

## Test plan
- Single CPU read addr 0x10, RAM holds 0x5A → mem_en at n+1 addr 0x10, ack0 with rdata 0x5A at n+2, gnt=01 both cycles.
- Both req at reset exit → CPU first (ack0), loader next (ack1 two cycles later), then alternation over 4 accesses.
- Loader write 0x3C to 0x20 → mem_we=1, mem_wdata 0x3C in ACCESS; readback by CPU returns 0x3C.
- Loader lock1=1 continuous, req0 held, MAX_LOCK=4 → four loader accesses, then one CPU access, then loader resumes.
- rst_n low during ACCESS → no ack, all outputs 0 next cycle, first tie after release goes to CPU.
